seq_mul_hs: RTL and testbench

Parametrised iterative shift-and-add multiplier, the next generation of the team's enable-loaded array multiplier. Operands arrive over a valid/ready input handshake, the product is computed over M cycles using one adder, and the result is held on a valid/ready output handshake. It adds a per-transaction signed/unsigned mode and output backpressure, and sits as a shared low-area multiply resource behind a datapath sequencer.

---
 rtl/seq_mul_hs.sv | 108 ++++++++++
 tb/tb_seq_mul_hs.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mul_hs.sv
// seq_mul_hs: iterative shift-and-add multiplier with valid/ready handshakes.
// One adder is reused across M cycles; signed operands are handled by
// multiplying magnitudes and negating the product at the end.
module seq_mul_hs #(
    parameter int M = 8,
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] dataA,
    input  logic [M-1:0] dataB,
    input  logic         signed_mode,
    output logic [N-1:0] P,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    // Elaboration-time guards on the parameters.
    if (N != 2 * M) begin : g_bad_n
        $error("seq_mul_hs: N must equal 2*M");
    end
    if (M < 2) begin : g_bad_m
        $error("seq_mul_hs: M must be at least 2");
    end

    localparam int CW = $clog2(M);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state;
    logic [N-1:0]   acc;
    logic [N-1:0]   a_sh;    // multiplicand magnitude, shifted to current bit position
    logic [M-1:0]   b_sh;    // multiplier magnitude, consumed LSB first
    logic [CW-1:0]  cnt;
    logic           neg;

    logic [M-1:0]   mag_a;
    logic [M-1:0]   mag_b;
    logic [N-1:0]   acc_nxt;

    // Operand magnitudes and the single shared adder.
    always_comb begin
        mag_a   = (signed_mode && dataA[M-1]) ? (~dataA + M'(1)) : dataA;
        mag_b   = (signed_mode && dataB[M-1]) ? (~dataB + M'(1)) : dataB;
        acc_nxt = acc + (b_sh[0] ? a_sh : '0);
    end

    // Control FSM with registered handshake outputs and the datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
            P         <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh     <= N'(mag_a);
                        b_sh     <= mag_b;
                        neg      <= signed_mode & (dataA[M-1] ^ dataB[M-1]);
                        acc      <= '0;
                        cnt      <= '0;
                        state    <= CALC;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                CALC: begin
                    acc  <= acc_nxt;
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + CW'(1);
                    // Last bit: fold the final partial product straight into P.
                    if (cnt == CW'(M - 1)) begin
                        P         <= neg ? (~acc_nxt + N'(1)) : acc_nxt;
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul_hs.sv
// tb_seq_mul_hs: directed and random checks of seq_mul_hs at M=8 and M=16.
module tb_seq_mul_hs;

    logic        clk = 1'b0;
    logic        rst_n;

    // M=8 instance signals
    logic        in_valid, in_ready, signed_mode, out_valid, out_ready, busy;
    logic [7:0]  dataA, dataB;
    logic [15:0] P;

    // M=16 instance signals
    logic        in_valid16, in_ready16, signed_mode16, out_valid16, out_ready16, busy16;
    logic [15:0] dataA16, dataB16;
    logic [31:0] P16;

    int n_chk  = 0;
    int n_fail = 0;
    int n_acc  = 0;
    int n_out  = 0;
    bit cnt_en = 1'b0;

    seq_mul_hs #(.M(8), .N(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .dataA(dataA), .dataB(dataB), .signed_mode(signed_mode), .P(P),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    seq_mul_hs #(.M(16), .N(32)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .dataA(dataA16), .dataB(dataB16), .signed_mode(signed_mode16), .P(P16),
        .out_valid(out_valid16), .out_ready(out_ready16), .busy(busy16)
    );

    always #5 clk = ~clk;

    // Handshake counters for the random phase.
    always @(posedge clk) begin
        if (cnt_en) begin
            if (in_valid && in_ready)   n_acc++;
            if (out_valid && out_ready) n_out++;
            if (in_valid16 && in_ready16)   n_acc++;
            if (out_valid16 && out_ready16) n_out++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
        int r;
        if (s) r = int'($signed(a)) * int'($signed(b));
        else   r = int'(a) * int'(b);
        return r[15:0];
    endfunction

    function automatic logic [31:0] ref16(input logic [15:0] a, input logic [15:0] b, input logic s);
        longint r;
        if (s) r = longint'($signed(a)) * longint'($signed(b));
        else   r = longint'(a) * longint'(b);
        return r[31:0];
    endfunction

    // One M=8 transaction. Returns P; optionally checks latency/busy length.
    task automatic mul8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input int stall, input bit chk_lat, output logic [15:0] p);
        int lat, nb, w;
        w = 0;
        while (!in_ready && w < 20) begin tick(); w++; end
        if (w >= 20) chk("in_ready_timeout", 0, 1);
        dataA = a; dataB = b; signed_mode = s; in_valid = 1'b1;
        tick();                       // accept edge
        in_valid = 1'b0;
        dataA = $urandom; dataB = $urandom; signed_mode = $urandom;
        lat = 0; nb = 0;
        while (!out_valid && lat < 40) begin
            if (busy) nb++;
            tick();
            lat++;
        end
        if (chk_lat) begin
            chk("latency", lat, 8);
            chk("busy_cycles", nb, 8);
        end
        if (lat >= 40) chk("out_valid_timeout", 0, 1);
        p = P;
        repeat (stall) begin
            tick();
            chk("stall_p", P, p);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        if (chk_lat) begin
            chk("release_out_valid", out_valid, 0);
            chk("release_in_ready", in_ready, 1);
        end
    endtask

    task automatic mul16(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input int stall, output logic [31:0] p);
        int lat;
        while (!in_ready16) tick();
        dataA16 = a; dataB16 = b; signed_mode16 = s; in_valid16 = 1'b1;
        tick();
        in_valid16 = 1'b0;
        lat = 0;
        while (!out_valid16 && lat < 60) begin tick(); lat++; end
        if (lat >= 60) chk("out_valid16_timeout", 0, 1);
        p = P16;
        repeat (stall) tick();
        out_ready16 = 1'b1;
        tick();
        out_ready16 = 1'b0;
    endtask

    initial begin
        logic [15:0] p, e;
        logic [31:0] p32;
        logic [7:0]  ra, rb;
        logic [15:0] ra16, rb16;
        logic        rs;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; signed_mode = 1'b0;
        dataA = '0; dataB = '0;
        in_valid16 = 1'b0; out_ready16 = 1'b0; signed_mode16 = 1'b0;
        dataA16 = '0; dataB16 = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_p", P, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);

        // Unsigned directed
        mul8(8'd200, 8'd150, 1'b0, 0, 1'b1, p); chk("u_200x150", p, 16'd30000);
        mul8(8'd255, 8'd255, 1'b0, 0, 1'b1, p); chk("u_255x255", p, 16'd65025);
        mul8(8'd0,   8'd173, 1'b0, 0, 1'b0, p); chk("u_0x173",   p, 16'd0);

        // Signed directed
        mul8(8'hFD, 8'h05, 1'b1, 0, 1'b0, p); chk("s_m3x5",       p, 16'hFFF1);
        mul8(8'h80, 8'h80, 1'b1, 0, 1'b0, p); chk("s_m128xm128",  p, 16'h4000);
        mul8(8'h80, 8'h7F, 1'b1, 0, 1'b0, p); chk("s_m128x127",   p, 16'hC080);
        mul8(8'h00, 8'hFF, 1'b1, 0, 1'b1, p); chk("s_0xm1",       p, 16'h0000);

        // Backpressure: 7*9 held while new operands 10*11 are offered
        dataA = 8'd7; dataB = 8'd9; signed_mode = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        chk("bp_out_valid", out_valid, 1);
        chk("bp_p", P, 16'd63);
        dataA = 8'd10; dataB = 8'd11; in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (P !== 16'd63 || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin
                chk("bp_hold", {P, 13'd0, out_valid, in_ready, busy}, {16'd63, 16'd4});
            end
        end
        chk("bp_hold_p", P, 16'd63);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_rel_in_ready", in_ready, 1);
        chk("bp_rel_out_valid", out_valid, 0);
        tick();                       // new operands accepted here
        in_valid = 1'b0;
        chk("bp_next_busy", busy, 1);
        repeat (8) tick();
        chk("bp_next_p", P, 16'd110);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // Reset on the 4th CALC edge
        dataA = 8'd5; dataB = 8'd6; signed_mode = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_p", P, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 1);
        repeat (10) begin
            tick();
            if (out_valid) chk("midrst_no_pulse", out_valid, 0);
        end
        mul8(8'd12, 8'd12, 1'b0, 0, 1'b1, p); chk("post_rst_12x12", p, 16'd144);

        // Mode capture: inputs scrambled during CALC by mul8
        mul8(8'hFF, 8'h02, 1'b1, 0, 1'b0, p); chk("mode_capture", p, 16'hFFFE);

        // Random regression with stalls
        cnt_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            ra = $urandom; rb = $urandom; rs = $urandom;
            e = ref8(ra, rb, rs);
            mul8(ra, rb, rs, $urandom_range(0, 3), 1'b0, p);
            chk("rand8", p, e);
        end
        for (int i = 0; i < 200; i++) begin
            ra16 = $urandom; rb16 = $urandom; rs = $urandom;
            mul16(ra16, rb16, rs, $urandom_range(0, 3), p32);
            chk("rand16", p32, ref16(ra16, rb16, rs));
        end
        mul16(16'h8000, 16'h8000, 1'b1, 0, p32); chk("s16_min_min", p32, 32'h4000_0000);
        mul16(16'hFFFF, 16'hFFFF, 1'b0, 0, p32); chk("u16_max_max", p32, 32'hFFFE_0001);
        tick();
        cnt_en = 1'b0;
        chk("acc_eq_out", n_out, n_acc);
        chk("acc_count", n_acc, 502);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
